// File: rtl/com_csr_decmux.sv
// CSR address-decode demux: routes one upstream CSR request to one of N_SLV slave windows,
// answering decode misses (and, with COM_CSR_DECMUX_TMO_EN defined, hung slaves) with an error.
module com_csr_decmux #(
  parameter int                AW_CSR   = 16,
  parameter int                DW_CSR   = 32,
  parameter int                SW_CSR   = DW_CSR / 8,
  parameter int                N_SLV    = 4,
  parameter int                SLV_AW   = 12,
  parameter int                TMO_CYC  = 255,
  parameter logic [DW_CSR-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic                    s_write,
  input  logic [AW_CSR-1:0]       s_addr,
  input  logic [DW_CSR-1:0]       s_wdata,
  input  logic [SW_CSR-1:0]       s_wstrb,
  output logic                    s_ready,
  output logic [DW_CSR-1:0]       s_rdata,
  output logic [N_SLV-1:0]        m_valid,
  output logic                    m_write,
  output logic [SLV_AW-1:0]       m_addr,
  output logic [DW_CSR-1:0]       m_wdata,
  output logic [SW_CSR-1:0]       m_wstrb,
  input  logic [N_SLV-1:0]        m_ready,
  input  logic [N_SLV*DW_CSR-1:0] m_rdata,
  output logic                    err_pulse,
  output logic [1:0]              err_code,
  output logic [AW_CSR-1:0]       err_addr
);

  localparam int SELW = $clog2(N_SLV);
  localparam int HIW  = AW_CSR - SLV_AW - SELW;

  localparam logic [1:0] ERR_DEC = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  if (N_SLV < 2 || (N_SLV & (N_SLV - 1)) != 0) begin : g_bad_nslv
    $error("com_csr_decmux: N_SLV must be a power of 2 and at least 2");
  end
  if (HIW < 0) begin : g_bad_aw
    $error("com_csr_decmux: AW_CSR too small for N_SLV windows of 2^SLV_AW bytes");
  end
  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("com_csr_decmux: TMO_CYC must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

  function automatic logic [N_SLV-1:0] sel_onehot(input logic [SELW-1:0] s);
    logic [N_SLV-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

  state_t              state_q, state_d;
  logic [N_SLV-1:0]    mvalid_q, mvalid_d;
  logic                mwrite_q, mwrite_d;
  logic [SLV_AW-1:0]   maddr_q, maddr_d;
  logic [DW_CSR-1:0]   mwdata_q, mwdata_d;
  logic [SW_CSR-1:0]   mwstrb_q, mwstrb_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic [DW_CSR-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          ecode_q, ecode_d;
  logic [AW_CSR-1:0]   eaddr_q, eaddr_d;

  // Decode of the incoming request
  logic [SELW-1:0] sel_in;
  logic            miss;
  assign sel_in = s_addr[SLV_AW +: SELW];

  if (HIW > 0) begin : g_hi
    assign miss = |s_addr[AW_CSR-1 : SLV_AW+SELW];
  end else begin : g_nohi
    assign miss = 1'b0;
  end

  logic [DW_CSR-1:0] slv_rdata [N_SLV];
  for (genvar i = 0; i < N_SLV; i++) begin : g_rd
    assign slv_rdata[i] = m_rdata[i*DW_CSR +: DW_CSR];
  end

  logic slv_ready;
  logic tmo_hit;
  assign slv_ready = m_ready[sel_q];

`ifdef COM_CSR_DECMUX_TMO_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // The limit cycle is the TMO_CYC-th FWD cycle; a ready in that cycle still completes normally.
  assign tmo_hit = !slv_ready && (cnt_q == CW'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_valid) state_d = miss ? RESP : FWD;
      FWD:     if (slv_ready || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mvalid_d = mvalid_q;
    mwrite_d = mwrite_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwstrb_d = mwstrb_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ecode_d  = ecode_q;
    eaddr_d  = eaddr_q;
`ifdef COM_CSR_DECMUX_TMO_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef COM_CSR_DECMUX_TMO_EN
        cnt_d = '0;
`endif
        if (s_valid) begin
          mwrite_d = s_write;
          maddr_d  = s_addr[SLV_AW-1:0];
          mwdata_d = s_wdata;
          mwstrb_d = s_wstrb;
          sel_d    = sel_in;
          err_d    = miss;
          if (miss) begin
            rdata_d = ERR_DATA;
            ecode_d = ERR_DEC;
            eaddr_d = s_addr;
          end else begin
            mvalid_d = sel_onehot(sel_in);
          end
        end
      end
      FWD: begin
        if (slv_ready) begin
          mvalid_d = '0;
          rdata_d  = slv_rdata[sel_q];
          err_d    = 1'b0;
        end else if (tmo_hit) begin
          // A hit has an all-zero upper field, so the full address rebuilds from sel and offset.
          mvalid_d = '0;
          rdata_d  = ERR_DATA;
          err_d    = 1'b1;
          ecode_d  = ERR_TMO;
          eaddr_d  = AW_CSR'({sel_q, maddr_q});
        end
`ifdef COM_CSR_DECMUX_TMO_EN
        if (!slv_ready) cnt_d = cnt_q + 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mvalid_q <= '0;
      mwrite_q <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwstrb_q <= '0;
      sel_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ecode_q  <= '0;
      eaddr_q  <= '0;
`ifdef COM_CSR_DECMUX_TMO_EN
      cnt_q    <= '0;
`endif
    end else begin
      mvalid_q <= mvalid_d;
      mwrite_q <= mwrite_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwstrb_q <= mwstrb_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ecode_q  <= ecode_d;
      eaddr_q  <= eaddr_d;
`ifdef COM_CSR_DECMUX_TMO_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    s_ready   = (state_q == RESP);
    err_pulse = (state_q == RESP) && err_q;
    s_rdata   = rdata_q;
    m_valid   = mvalid_q;
    m_write   = mwrite_q;
    m_addr    = maddr_q;
    m_wdata   = mwdata_q;
    m_wstrb   = mwstrb_q;
    err_code  = ecode_q;
    err_addr  = eaddr_q;
  end

endmodule

// File: tb/tb_com_csr_decmux.sv
// Bench for com_csr_decmux: table of transactions, per-transaction slave model, response scoreboard.
module tb_com_csr_decmux;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_write;
  logic [15:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_ready;
  logic [31:0]  s_rdata;
  logic [3:0]   m_valid;
  logic         m_write;
  logic [11:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic [3:0]   m_ready;
  logic [127:0] m_rdata;
  logic         err_pulse;
  logic [1:0]   err_code;
  logic [15:0]  err_addr;

  com_csr_decmux dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .err_pulse(err_pulse), .err_code(err_code), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          rdly;     // slave wait cycles before ready; -1 = never
    logic [3:0]  exp_mv;
    logic [31:0] exp_rd;
    int          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    int          err;
    logic [15:0] addr;
    int          start;
    int          lat;
  } exp_t;

  vec_t        vecs[11];
  exp_t        sbq[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [1:0]  last_code = 2'd0;
  logic [15:0] last_addr = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (s_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_s_ready", s_ready, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("latency", cyc - mon_e.start, mon_e.lat);
          if (mon_e.chk_rd) chk("s_rdata", s_rdata, mon_e.rd);
          chk("err_pulse", err_pulse, mon_e.err != 0);
          if (mon_e.err != 0) begin
            last_code = mon_e.err[1:0];
            last_addr = mon_e.addr;
          end
          chk("err_code", err_code, last_code);
          chk("err_addr", err_addr, last_addr);
        end
      end else if (err_pulse) begin
        chk("err_pulse_idle", err_pulse, 0);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_s_rdata"}, s_rdata, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_write"}, m_write, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_wstrb"}, m_wstrb, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask

  // at_neg: start on the current negedge (chained after a RESP); hold: leave s_valid high at the end.
  task automatic run_txn(input vec_t v, input bit at_neg, input bit hold);
    int   w, mv_cnt, mv_exp;
    bit   seen, done;
    exp_t e;
    if (!at_neg) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_write = v.wr;
    s_addr  = v.addr;
    s_wdata = v.wdata;
    s_wstrb = v.wstrb;
    e.rd     = v.exp_rd;
    e.chk_rd = !v.wr || (v.exp_err != 0);
    e.err    = v.exp_err;
    e.addr   = v.addr;
    e.lat    = v.exp_lat;
    e.start  = at_neg ? cyc + 1 : cyc;
    sbq.push_back(e);
    w = 0; mv_cnt = 0; seen = 0; done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      m_ready = '0;
      if (s_ready) begin
        done = 1;
      end else if (m_valid != '0) begin
        mv_cnt++;
        if (!seen) begin
          seen = 1;
          chk("m_valid", m_valid, v.exp_mv);
          chk("m_addr", m_addr, v.addr[11:0]);
          chk("m_write", m_write, v.wr);
          if (v.wr) begin
            chk("m_wdata", m_wdata, v.wdata);
            chk("m_wstrb", m_wstrb, v.wstrb);
          end
        end
        // Unselected slaves shout ready while the selected one is still busy.
        if (v.rdly >= 0 && w == v.rdly) m_ready = v.exp_mv;
        else                            m_ready = ~v.exp_mv;
        w++;
      end
    end
    if (!done) chk("txn_done", done, 1);
    mv_exp = (v.exp_err == 1) ? 0 : ((v.rdly < 0) ? 255 : v.rdly + 1);
    chk("m_valid_cycles", mv_cnt, mv_exp);
    if (!hold) s_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    //           wr    addr      wdata          strb   dly  mv       rdata          err lat
    vecs[0]  = '{1'b1, 16'h1010, 32'h1234_5678, 4'hF,  2,   4'b0010, 32'h0,         0,  4};
    vecs[1]  = '{1'b0, 16'h2004, 32'h0,         4'h0,  0,   4'b0100, 32'hCAFE_0002, 0,  2};
    vecs[2]  = '{1'b0, 16'h8000, 32'h0,         4'h0,  0,   4'b0000, 32'hDEAD_BEEF, 1,  1};
    vecs[3]  = '{1'b0, 16'h0ABC, 32'h0,         4'h0,  1,   4'b0001, 32'hCAFE_0000, 0,  3};
    vecs[4]  = '{1'b1, 16'h3FFC, 32'hA5A5_A5A5, 4'h3,  0,   4'b1000, 32'h0,         0,  2};
    vecs[5]  = '{1'b1, 16'h4004, 32'h1111_1111, 4'hF,  0,   4'b0000, 32'hDEAD_BEEF, 1,  1};
    vecs[6]  = '{1'b0, 16'h1FFF, 32'h0,         4'h0,  3,   4'b0010, 32'hCAFE_0001, 0,  5};
    vecs[7]  = '{1'b1, 16'h0020, 32'h0BAD_F00D, 4'hC,  1,   4'b0001, 32'h0,         0,  3};
    vecs[8]  = '{1'b1, 16'h1040, 32'h600D_CAFE, 4'hF,  0,   4'b0010, 32'h0,         0,  2};
`ifdef COM_CSR_DECMUX_TMO_EN
    vecs[9]  = '{1'b0, 16'h3104, 32'h0,         4'h0,  254, 4'b1000, 32'hCAFE_0003, 0,  256};
    vecs[10] = '{1'b0, 16'h3000, 32'h0,         4'h0,  -1,  4'b1000, 32'hDEAD_BEEF, 2,  256};
`else
    vecs[9]  = '{1'b0, 16'h3100, 32'h0,         4'h0,  300, 4'b1000, 32'hCAFE_0003, 0,  302};
    vecs[10] = '{1'b0, 16'hC010, 32'h0,         4'h0,  0,   4'b0000, 32'hDEAD_BEEF, 1,  1};
`endif

    for (int i = 0; i < 4; i++) m_rdata[i*32 +: 32] = 32'hCAFE_0000 + i;
    rst = 1'b1; s_valid = 1'b0; s_write = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    m_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst0");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1'b0, 1'b0);

    // Back-to-back: second request presented in the RESP cycle of the first.
    run_txn(vecs[7], 1'b0, 1'b1);
    run_txn(vecs[8], 1'b1, 1'b0);

    run_txn(vecs[9], 1'b0, 1'b0);
    run_txn(vecs[10], 1'b0, 1'b0);
`ifdef COM_CSR_DECMUX_TMO_EN
    // Late ready from the timed-out slave must not complete anything.
    @(negedge clk); m_ready = 4'b1000;
    @(negedge clk); m_ready = 4'b0000;
    repeat (3) @(negedge clk);
`endif

    // Reset while slave 2 is being accessed.
    @(posedge clk); #1;
    s_valid = 1'b1; s_write = 1'b0; s_addr = 16'h2008;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (m_valid == 4'b0100) found = 1;
    end
    chk("rstfwd_m_valid", m_valid, 4'b0100);
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_code = 2'd0;
    last_addr = 16'h0;
    @(negedge clk);
    chk_reset_vals("rstfwd");
    m_ready = 4'b0100;
    @(negedge clk);
    m_ready = 4'b0000;
    repeat (5) @(negedge clk);
    chk("rstfwd_m_valid_after", m_valid, 0);

    // A fresh read after the aborted one still works.
    run_txn(vecs[1], 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
